cmsdk_mcu_mtx_input_hold: RTL

//  Per-master input stage of the AHB-Lite bus matrix; the requesting side of each output-port arbiter.

---
 rtl/cmsdk_mcu_mtx_input_hold.sv | 121 ++++++++++++
 1 files changed

// File: rtl/cmsdk_mcu_mtx_input_hold.sv
// Per-master input stage of the AHB-Lite bus matrix: holds an address phase the target
// output port cannot take yet, requests arbitration and stalls the master until accepted.
module cmsdk_mcu_mtx_input_hold #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSELS,
  input  logic [ADDR_WIDTH-1:0] HADDRS,
  input  logic [1:0]            HTRANSS,
  input  logic                  HWRITES,
  input  logic [2:0]            HSIZES,
  input  logic [2:0]            HBURSTS,
  input  logic [3:0]            HPROTS,
  input  logic                  HMASTLOCKS,
  input  logic                  HREADYS,
  output logic                  HREADYOUTS,
  output logic                  HRESPS,
  output logic [ADDR_WIDTH-1:0] HADDRI,
  output logic [1:0]            HTRANSI,
  output logic                  HWRITEI,
  output logic [2:0]            HSIZEI,
  output logic [2:0]            HBURSTI,
  output logic [3:0]            HPROTI,
  output logic                  HMASTLOCKI,
  output logic                  trans_req,
  input  logic                  addr_taken,
  input  logic                  data_own,
  input  logic                  HREADYOUTM,
  input  logic                  HRESPM
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [1:0]            trans;
    logic                  write;
    logic [2:0]            size;
    logic [2:0]            burst;
    logic [3:0]            prot;
    logic                  lock;
  } addr_phase_t;

  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;

  state_e      state_q, state_d;
  addr_phase_t hold_q, hold_d;
  addr_phase_t live;
  logic        new_tx;
  state_e      start_state;

  assign live = '{addr: HADDRS, trans: HTRANSS, write: HWRITES, size: HSIZES,
                  burst: HBURSTS, prot: HPROTS, lock: HMASTLOCKS};

  // Reset gates new_tx so no request escapes while HRESETn is low.
  assign new_tx = HRESETn & HSELS & HREADYS & HTRANSS[1];

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latch).
    state_d     = state_q;
    hold_d      = hold_q;
    start_state = ST_IDLE;
    if (new_tx) start_state = addr_taken ? ST_DATA : ST_WAIT;

    case (state_q)
      ST_IDLE: state_d = start_state;
      ST_WAIT: if (addr_taken) state_d = ST_DATA;
      ST_DATA: if (data_own && HREADYOUTM) state_d = start_state;
      default: state_d = ST_IDLE;
    endcase

    if (new_tx && !addr_taken) hold_d = live;
  end

  always_ff @(posedge HCLK) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
    if (!HRESETn) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    HADDRI     = live.addr;
    HTRANSI    = live.trans & {2{HSELS & HREADYS}};
    HWRITEI    = live.write;
    HSIZEI     = live.size;
    HBURSTI    = live.burst;
    HPROTI     = live.prot;
    HMASTLOCKI = live.lock;
    HREADYOUTS = 1'b1;
    HRESPS     = 1'b0;

    if (state_q == ST_WAIT) begin
      // Arbitration may have broken the burst, so a held SEQ restarts as NONSEQ.
      HADDRI     = hold_q.addr;
      HTRANSI    = (hold_q.trans == TRANS_SEQ) ? TRANS_NONSEQ : hold_q.trans;
      HWRITEI    = hold_q.write;
      HSIZEI     = hold_q.size;
      HBURSTI    = hold_q.burst;
      HPROTI     = hold_q.prot;
      HMASTLOCKI = hold_q.lock;
      HREADYOUTS = 1'b0;
    end else if (state_q == ST_DATA && data_own) begin
      HREADYOUTS = HREADYOUTM;
      HRESPS     = HRESPM;
    end
  end

  assign trans_req = (state_q == ST_WAIT) | new_tx;

endmodule
